// File: rtl/melody_if.sv
`default_nettype none
// ============================================================================
//  Module   : melody_if
//  Purpose  : Request, score-ROM and tone-generator signals of the melody
//             scheduler, with master (scheduler) and slave (environment) views.
//  Revision : 1.0  initial release
// ============================================================================
interface melody_if #(
    parameter int ROM_AW = 6
) ();
    logic              req_alarm;
    logic              req_chime;
    logic              stop;
    logic [ROM_AW-1:0] rom_addr;
    logic [8:0]        rom_data;
    logic [5:0]        din;
    logic              tran_vld;
    logic              tran_end;
    logic              busy;
    logic [1:0]        owner;

    modport master (
        input  req_alarm, req_chime, stop, rom_data,
        output rom_addr, din, tran_vld, tran_end, busy, owner
    );

    modport slave (
        output req_alarm, req_chime, stop, rom_data,
        input  rom_addr, din, tran_vld, tran_end, busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/melody_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : melody_scheduler
//  Purpose  : Arbitrates alarm/chime requests, walks the score ROM and drives
//             the tone generator din/tran_vld/tran_end handshake.
//  Revision : 1.0  initial release
// ============================================================================
module melody_scheduler #(
    parameter int                BEAT_CYC   = 12_500_000,
    parameter int                ROM_AW     = 6,
    parameter logic [ROM_AW-1:0] ALARM_BASE = '0,
    parameter logic [ROM_AW-1:0] CHIME_BASE = ROM_AW'(32)
) (
    input  wire       sysclk,
    input  wire       rst_n,
    melody_if.master  bus
);
    localparam int               CNT_W  = $clog2(7 * BEAT_CYC);
    localparam logic [CNT_W-1:0] BEAT_W = CNT_W'(BEAT_CYC);

    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_CHIME = 2'b01;
    localparam logic [1:0] OWN_ALARM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_PLAY  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  dur_cnt, dur_cnt_next;
    logic [ROM_AW-1:0] rom_addr_next;
    logic [5:0]        din_next;
    logic              tran_vld_next, tran_end_next, busy_next;
    logic [1:0]        owner_next;
    logic              go_fin;
    logic [2:0]        note_dur;

    assign note_dur = bus.rom_data[8:6];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            dur_cnt      <= '0;
            bus.rom_addr <= '0;
            bus.din      <= '0;
            bus.tran_vld <= 1'b0;
            bus.tran_end <= 1'b0;
            bus.busy     <= 1'b0;
            bus.owner    <= OWN_NONE;
        end else begin
            state        <= state_next;
            dur_cnt      <= dur_cnt_next;
            bus.rom_addr <= rom_addr_next;
            bus.din      <= din_next;
            bus.tran_vld <= tran_vld_next;
            bus.tran_end <= tran_end_next;
            bus.busy     <= busy_next;
            bus.owner    <= owner_next;
        end
    end

    always_comb begin
        state_next    = state;
        dur_cnt_next  = dur_cnt;
        rom_addr_next = bus.rom_addr;
        din_next      = bus.din;
        tran_vld_next = 1'b0;
        tran_end_next = 1'b0;
        busy_next     = bus.busy;
        owner_next    = bus.owner;
        go_fin        = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.req_alarm) begin
                    rom_addr_next = ALARM_BASE;
                    owner_next    = OWN_ALARM;
                    busy_next     = 1'b1;
                    state_next    = S_FETCH;
                end else if (bus.req_chime) begin
                    rom_addr_next = CHIME_BASE;
                    owner_next    = OWN_CHIME;
                    busy_next     = 1'b1;
                    state_next    = S_FETCH;
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_LOAD;
            S_LOAD: begin
                if (note_dur == 3'd0) begin
                    go_fin = 1'b1;
                end else begin
                    din_next      = bus.rom_data[5:0];
                    tran_vld_next = 1'b1;
                    dur_cnt_next  = CNT_W'(note_dur) * BEAT_W - CNT_W'(1);
                    state_next    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (dur_cnt == '0) begin
                    rom_addr_next = bus.rom_addr + ROM_AW'(1);
                    state_next    = S_FETCH;
                end else begin
                    dur_cnt_next = dur_cnt - CNT_W'(1);
                end
            end
            S_FIN: begin
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Stop beats a preempting alarm; a preempting alarm beats end-of-song.
        if (state != S_IDLE && state != S_FIN) begin
            if (bus.stop) begin
                go_fin = 1'b1;
            end else if (bus.req_alarm && bus.owner == OWN_CHIME) begin
                go_fin        = 1'b0;
                rom_addr_next = ALARM_BASE;
                owner_next    = OWN_ALARM;
                tran_vld_next = 1'b0;
                state_next    = S_FETCH;
            end
        end

        if (go_fin) begin
            state_next    = S_FIN;
            tran_end_next = 1'b1;
            tran_vld_next = 1'b0;
            din_next      = '0;
            owner_next    = OWN_NONE;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_melody_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_melody_scheduler
//  Purpose  : Directed bench for melody_scheduler with a score-ROM model and
//             an event scoreboard of expected tran_vld/tran_end pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_melody_scheduler;
    localparam int B = 4;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;

    logic [8:0] rom [64];

    typedef struct {
        bit         is_end;
        logic [5:0] note;
        int         at;
    } ev_t;
    ev_t expq [$];

    melody_if #(.ROM_AW(6)) bus ();

    melody_scheduler #(
        .BEAT_CYC   (B),
        .ROM_AW     (6),
        .ALARM_BASE (6'd0),
        .CHIME_BASE (6'd32)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus.master)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;
    always @(posedge sysclk) bus.rom_data <= rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Walks the ROM image and predicts each note start and the final end pulse.
    function automatic void push_song(input logic [5:0] base, input int start, input int maxn);
        logic [5:0] a = base;
        int         t = start + 3;
        ev_t        e;
        for (int i = 0; i < maxn; i++) begin
            if (rom[a][8:6] == 3'd0) begin
                e.is_end = 1'b1; e.note = '0; e.at = t;
                expq.push_back(e);
                return;
            end
            e.is_end = 1'b0; e.note = rom[a][5:0]; e.at = t;
            expq.push_back(e);
            t = t + int'(rom[a][8:6]) * B + 3;
            a = a + 6'd1;
        end
    endfunction

    always @(negedge sysclk) begin : mon
        ev_t e;
        if (rst_n && (bus.tran_vld || bus.tran_end)) begin
            if (expq.size() == 0) begin
                check("spurious_evt", {30'd0, bus.tran_end, bus.tran_vld}, 32'd0);
            end else begin
                e = expq.pop_front();
                check("evt_kind", {31'd0, bus.tran_end}, {31'd0, e.is_end});
                check("evt_cycle", cyc, e.at);
                if (e.is_end) begin
                    check("end_busy", {31'd0, bus.busy}, 32'd1);
                    check("end_owner", {30'd0, bus.owner}, 32'd0);
                    check("end_din", {26'd0, bus.din}, 32'd0);
                end else begin
                    check("vld_din", {26'd0, bus.din}, {26'd0, e.note});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic pulse(input logic a, input logic c, input logic s, output int acc);
        bus.req_alarm = a;
        bus.req_chime = c;
        bus.stop      = s;
        @(posedge sysclk);
        #1;
        bus.req_alarm = 1'b0;
        bus.req_chime = 1'b0;
        bus.stop      = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_q(input string tag, input int n, input int budget);
        int k = 0;
        while (expq.size() > n && k < budget) begin
            step(1);
            k++;
        end
        if (expq.size() > n) check(tag, expq.size(), n);
    endtask

    task automatic push_end(input int at);
        ev_t e;
        e.is_end = 1'b1; e.note = '0; e.at = at;
        expq.push_back(e);
    endtask

    initial begin
        int acc;
        bus.req_alarm = 1'b0;
        bus.req_chime = 1'b0;
        bus.stop      = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0]  = {3'd2, 6'b010_001};
        rom[1]  = {3'd1, 6'b010_011};
        rom[32] = {3'd7, 6'b100_010};

        step(3);
        check("rst_addr", {26'd0, bus.rom_addr}, 32'd0);
        check("rst_din", {26'd0, bus.din}, 32'd0);
        check("rst_vld", {31'd0, bus.tran_vld}, 32'd0);
        check("rst_end", {31'd0, bus.tran_end}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_owner", {30'd0, bus.owner}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // plain alarm melody
        pulse(1'b1, 1'b0, 1'b0, acc);
        push_song(6'd0, acc, 8);
        check("alarm_owner", {30'd0, bus.owner}, 32'd2);
        check("alarm_addr", {26'd0, bus.rom_addr}, 32'd0);
        check("alarm_busy", {31'd0, bus.busy}, 32'd1);
        wait_q("alarm_timeout", 0, 100);
        check("alarm_busy_low", {31'd0, bus.busy}, 32'd0);
        check("alarm_owner_clr", {30'd0, bus.owner}, 32'd0);
        step(2);

        // simultaneous requests: alarm wins
        pulse(1'b1, 1'b1, 1'b0, acc);
        push_song(6'd0, acc, 8);
        check("both_owner", {30'd0, bus.owner}, 32'd2);
        check("both_addr", {26'd0, bus.rom_addr}, 32'd0);
        wait_q("both_timeout", 0, 100);
        step(2);

        // alarm preempts a playing chime
        pulse(1'b0, 1'b1, 1'b0, acc);
        push_song(6'd32, acc, 1);
        check("chime_owner", {30'd0, bus.owner}, 32'd1);
        check("chime_addr", {26'd0, bus.rom_addr}, 32'd32);
        wait_q("chime_timeout", 0, 20);
        step(4);
        pulse(1'b1, 1'b0, 1'b0, acc);
        push_song(6'd0, acc, 8);
        check("preempt_owner", {30'd0, bus.owner}, 32'd2);
        check("preempt_addr", {26'd0, bus.rom_addr}, 32'd0);
        wait_q("preempt_timeout", 0, 100);
        step(2);

        // chime and repeated alarm ignored while alarm plays
        pulse(1'b1, 1'b0, 1'b0, acc);
        push_song(6'd0, acc, 8);
        wait_q("ign_n1_timeout", 2, 20);
        step(2);
        pulse(1'b0, 1'b1, 1'b0, acc);
        check("ign_chime_owner", {30'd0, bus.owner}, 32'd2);
        check("ign_chime_addr", {26'd0, bus.rom_addr}, 32'd0);
        wait_q("ign_n2_timeout", 1, 30);
        pulse(1'b1, 1'b0, 1'b0, acc);
        check("ign_alarm_addr", {26'd0, bus.rom_addr}, 32'd1);
        check("ign_alarm_owner", {30'd0, bus.owner}, 32'd2);
        wait_q("ign_end_timeout", 0, 30);
        step(2);

        // stop during an alarm note
        pulse(1'b1, 1'b0, 1'b0, acc);
        push_song(6'd0, acc, 1);
        wait_q("stop_a_timeout", 0, 20);
        step(2);
        pulse(1'b0, 1'b0, 1'b1, acc);
        push_end(acc);
        check("stop_owner", {30'd0, bus.owner}, 32'd0);
        check("stop_din", {26'd0, bus.din}, 32'd0);
        step(1);
        check("stop_busy_low", {31'd0, bus.busy}, 32'd0);
        step(2);

        // stop and alarm together during a chime: stop wins
        pulse(1'b0, 1'b1, 1'b0, acc);
        push_song(6'd32, acc, 1);
        wait_q("stop_c_timeout", 0, 20);
        step(2);
        pulse(1'b1, 1'b0, 1'b1, acc);
        push_end(acc);
        check("stopalarm_owner", {30'd0, bus.owner}, 32'd0);
        step(1);
        check("stopalarm_busy", {31'd0, bus.busy}, 32'd0);
        step(2);

        // unterminated chime wraps past address 63, then reset mid-note
        for (int i = 32; i < 64; i++) rom[i] = {3'd1, 3'b100, 3'(i % 8)};
        pulse(1'b0, 1'b1, 1'b0, acc);
        push_song(6'd32, acc, 33);
        wait_q("wrap_timeout", 0, 400);
        check("wrap_addr", {26'd0, bus.rom_addr}, 32'd0);
        check("wrap_din", {26'd0, bus.din}, 32'h11);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_din", {26'd0, bus.din}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_owner", {30'd0, bus.owner}, 32'd0);
        check("arst_end", {31'd0, bus.tran_end}, 32'd0);
        step(3);
        rst_n = 1'b1;
        step(10);
        check("no_tail_events", expq.size(), 32'd0);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
